match_controller: RTL and testbench

Sequences a multi-round tug-of-war match around the existing per-round playfield and victory logic. It gates play, issues a one-cycle round restart pulse after a timed pause, and keeps both players' scores. It declares the match winner at WIN_SCORE and drives both score displays. It sits between the victory detector (input: round-win pulses) and the playfield LEDs (output: restart and play enable).

---
 rtl/match_pkg.sv | 15 +
 rtl/seg7.sv | 26 ++
 rtl/match_controller.sv | 133 +++++++++++++
 tb/tb_match_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and widths for the tug-of-war match controller.
// Imported by the controller and the score display decoder.
package match_pkg;

    localparam int SCORE_W = 3;
    localparam int PCNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

endpackage

// File: rtl/seg7.sv
// BCD digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
// Codes above 9 blank the display.
module seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup, no state.
    always_comb begin
        seg = 7'b1111111;
        unique case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/match_controller.sv
// Multi-round match sequencer: gates play, times the inter-round pause,
// keeps scores and declares the champion; drives both score displays.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               win_l,
    input  logic               win_r,
    output logic               play_en,
    output logic               round_rst,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               champ_l,
    output logic               champ_r,
    output logic [6:0]         hex_l,
    output logic [6:0]         hex_r
);

    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
    localparam logic [PCNT_W-1:0]  PAUSE_LD = PCNT_W'(PAUSE_CYCLES - 1);

    state_t              state, state_n;
    logic [PCNT_W-1:0]   pcnt, pcnt_n;
    logic [SCORE_W-1:0]  score_l_n, score_r_n;
    logic                champ_l_n, champ_r_n;
    logic                round_rst_n;
    logic                play_en_n;
    logic [SCORE_W-1:0]  inc_l, inc_r;

    assign inc_l = score_l + 1'b1;
    assign inc_r = score_r + 1'b1;

    // State, scores, pause counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pcnt      <= '0;
            score_l   <= '0;
            score_r   <= '0;
            champ_l   <= 1'b0;
            champ_r   <= 1'b0;
            round_rst <= 1'b0;
            play_en   <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            champ_l   <= champ_l_n;
            champ_r   <= champ_r_n;
            round_rst <= round_rst_n;
            play_en   <= play_en_n;
        end
    end

    // Next-state and next-output decision for the whole match.
    always_comb begin
        state_n     = state;
        pcnt_n      = pcnt;
        score_l_n   = score_l;
        score_r_n   = score_r;
        champ_l_n   = champ_l;
        champ_r_n   = champ_r;
        round_rst_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n     = PLAY;
                    round_rst_n = 1'b1;
                end
            end
            PLAY: begin
                // Simultaneous wins are a tie and score nothing.
                if (win_l && !win_r) begin
                    score_l_n = inc_l;
                    if (inc_l == WIN_VAL) begin
                        state_n   = OVER;
                        champ_l_n = 1'b1;
                    end else begin
                        state_n = PAUSE;
                        pcnt_n  = PAUSE_LD;
                    end
                end else if (win_r && !win_l) begin
                    score_r_n = inc_r;
                    if (inc_r == WIN_VAL) begin
                        state_n   = OVER;
                        champ_r_n = 1'b1;
                    end else begin
                        state_n = PAUSE;
                        pcnt_n  = PAUSE_LD;
                    end
                end
            end
            PAUSE: begin
                if (pcnt == '0) begin
                    state_n     = PLAY;
                    round_rst_n = 1'b1;
                end else begin
                    pcnt_n = pcnt - 1'b1;
                end
            end
            OVER: begin
                if (start) begin
                    score_l_n   = '0;
                    score_r_n   = '0;
                    champ_l_n   = 1'b0;
                    champ_r_n   = 1'b0;
                    state_n     = PLAY;
                    round_rst_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Presses are blocked while the playfield is being recentred.
        play_en_n = (state_n == PLAY) && !round_rst_n;
    end

    seg7 u_seg_l (
        .bcd ({1'b0, score_l}),
        .seg (hex_l)
    );

    seg7 u_seg_r (
        .bcd ({1'b0, score_r}),
        .seg (hex_r)
    );

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with WIN_SCORE=3, PAUSE_CYCLES=4.
// Expected values are hand-derived cycle by cycle.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       reset, start, win_l, win_r;
    logic       play_en, round_rst, champ_l, champ_r;
    logic [2:0] score_l, score_r;
    logic [6:0] hex_l, hex_r;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;

    match_controller #(
        .WIN_SCORE    (3),
        .PAUSE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .win_l     (win_l),
        .win_r     (win_r),
        .play_en   (play_en),
        .round_rst (round_rst),
        .score_l   (score_l),
        .score_r   (score_r),
        .champ_l   (champ_l),
        .champ_r   (champ_r),
        .hex_l     (hex_l),
        .hex_r     (hex_r)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic pe, input logic rr);
        chk({tag, ".play_en"}, {7'd0, play_en}, {7'd0, pe});
        chk({tag, ".round_rst"}, {7'd0, round_rst}, {7'd0, rr});
    endtask

    task automatic pulse(input logic l, input logic r);
        win_l = l;
        win_r = r;
        tick();
        win_l = 1'b0;
        win_r = 1'b0;
    endtask

    // After a non-final round win: 3 more PAUSE cycles, round_rst, play.
    task automatic ride_pause(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl({tag, ".pause"}, 1'b0, 1'b0);
        end
        tick();
        chk_ctl({tag, ".rr"}, 1'b0, 1'b1);
        tick();
        chk_ctl({tag, ".play"}, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        win_l = 1'b0;
        win_r = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_ctl("rst", 1'b0, 1'b0);
        chk("rst.score_l", {5'd0, score_l}, 8'd0);
        chk("rst.score_r", {5'd0, score_r}, 8'd0);
        chk("rst.champ", {6'd0, champ_l, champ_r}, 8'd0);
        chk("rst.hex_l", {1'b0, hex_l}, {1'b0, H0});
        chk("rst.hex_r", {1'b0, hex_r}, {1'b0, H0});

        reset = 1'b0;
        tick();
        chk_ctl("idle", 1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk_ctl("start", 1'b0, 1'b1);
        tick();
        chk_ctl("start+1", 1'b1, 1'b0);

        pulse(1'b1, 1'b0);
        chk("r1.score_l", {5'd0, score_l}, 8'd1);
        chk("r1.hex_l", {1'b0, hex_l}, {1'b0, H1});
        chk_ctl("r1.win", 1'b0, 1'b0);
        win_r = 1'b1;
        tick();
        win_r = 1'b0;
        chk("r1.ign_r", {5'd0, score_r}, 8'd0);
        chk_ctl("r1.p1", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_ctl("r1.pause", 1'b0, 1'b0);
        end
        tick();
        chk_ctl("r1.rr", 1'b0, 1'b1);
        tick();
        chk_ctl("r1.play", 1'b1, 1'b0);
        chk("r1.score_r", {5'd0, score_r}, 8'd0);

        pulse(1'b1, 1'b1);
        chk("tie.score_l", {5'd0, score_l}, 8'd1);
        chk("tie.score_r", {5'd0, score_r}, 8'd0);
        chk_ctl("tie", 1'b1, 1'b0);

        pulse(1'b0, 1'b1);
        chk("r2.score_r", {5'd0, score_r}, 8'd1);
        ride_pause("r2");
        pulse(1'b0, 1'b1);
        chk("r3.score_r", {5'd0, score_r}, 8'd2);
        chk("r3.hex_r", {1'b0, hex_r}, {1'b0, H2});
        ride_pause("r3");

        pulse(1'b0, 1'b1);
        chk("fin.score_r", {5'd0, score_r}, 8'd3);
        chk("fin.hex_r", {1'b0, hex_r}, {1'b0, H3});
        chk("fin.champ", {6'd0, champ_l, champ_r}, 8'd1);
        chk_ctl("fin", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            win_l = (i == 1);
            win_r = (i == 3);
            tick();
            chk_ctl("over", 1'b0, 1'b0);
        end
        win_l = 1'b0;
        win_r = 1'b0;
        chk("over.score_l", {5'd0, score_l}, 8'd1);
        chk("over.score_r", {5'd0, score_r}, 8'd3);
        chk("over.champ", {6'd0, champ_l, champ_r}, 8'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("new.score_l", {5'd0, score_l}, 8'd0);
        chk("new.score_r", {5'd0, score_r}, 8'd0);
        chk("new.champ", {6'd0, champ_l, champ_r}, 8'd0);
        chk_ctl("new", 1'b0, 1'b1);
        tick();
        chk_ctl("new+1", 1'b1, 1'b0);

        pulse(1'b1, 1'b0);
        ride_pause("m1");
        pulse(1'b1, 1'b0);
        chk("m2.score_l", {5'd0, score_l}, 8'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst.score_l", {5'd0, score_l}, 8'd0);
        chk("mrst.hex_l", {1'b0, hex_l}, {1'b0, H0});
        chk_ctl("mrst", 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_ctl("mrst.idle", 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
